// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_INC   = 2'd1,
    SLOT_LOAD1 = 2'd2,
    SLOT_CLR   = 2'd3
  } slot_cmd_e;

  localparam int unsigned MISS_W = 4;

  function automatic int unsigned slot_w(input int unsigned channels);
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Stream-in / channels-out bundle for tdm_demux.
// TDM_DEMUX_PARITY_EN widens din by one parity bit and adds parity_err.
interface tdm_demux_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned DIN_W = WIDTH + 1;
`else
  localparam int unsigned DIN_W = WIDTH;
`endif

  logic [DIN_W-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]       ch_valid;
  logic                      frame_done;
  logic                      locked;
  logic                      sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic                      parity_err;

  modport master (output din, din_valid, frame_sync,
                  input  ch_data, ch_valid, frame_done, locked, sync_err, parity_err);
  modport slave  (input  din, din_valid, frame_sync,
                  output ch_data, ch_valid, frame_done, locked, sync_err, parity_err);
`else
  modport master (output din, din_valid, frame_sync,
                  input  ch_data, ch_valid, frame_done, locked, sync_err);
  modport slave  (input  din, din_valid, frame_sync,
                  output ch_data, ch_valid, frame_done, locked, sync_err);
`endif

endinterface

// File: rtl/tdm_demux_slot_counter.sv
// Expected-slot counter: wraps at CHANNELS-1, loads 1 on realign, clears on lock loss.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SW       = slot_w(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  slot_cmd_e     cmd,
  output logic [SW-1:0] slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else begin
      case (cmd)
        SLOT_INC:   slot <= (slot == SW'(CHANNELS - 1)) ? '0 : slot + SW'(1);
        SLOT_LOAD1: slot <= SW'(1);
        SLOT_CLR:   slot <= '0;
        default:    slot <= slot;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive end: frame-sync alignment, flywheel lock tracking, per-channel registers.
// Optional TDM_DEMUX_PARITY_EN adds an even-parity MSB on din and a parity_err pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned MISS_LIMIT = 3
) (
  input logic        clk,
  input logic        rst_n,
  tdm_demux_if.slave bus
);

  localparam int unsigned SW = slot_w(CHANNELS);

  state_e                    state;
  state_e                    state_nxt_c;
  logic [MISS_W-1:0]         miss_cnt;
  logic [MISS_W-1:0]         miss_nxt_c;
  logic [MISS_W-1:0]         miss_inc_c;
  logic [SW-1:0]             slot;
  slot_cmd_e                 slot_cmd_c;
  logic                      wr_en_c;
  logic                      wr_ok_c;
  logic [SW-1:0]             wr_idx_c;
  logic                      sync_err_c;
  logic                      parity_ok_c;
  logic [WIDTH-1:0]          wr_data_c;
  logic [CHANNELS*WIDTH-1:0] ch_data_q;
  logic [CHANNELS-1:0]       ch_valid_q;
  logic                      frame_done_q;
  logic                      sync_err_q;

  tdm_slot_counter #(.CHANNELS(CHANNELS), .SW(SW)) u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (slot_cmd_c),
    .slot  (slot)
  );

  assign wr_data_c  = bus.din[WIDTH-1:0];
  assign miss_inc_c = miss_cnt + MISS_W'(1);

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_err_q;
  // Parity MSB makes the whole word even; an odd word is rejected from storage only.
  assign parity_ok_c    = ~(^bus.din);
  assign bus.parity_err = parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= bus.din_valid && !parity_ok_c;
  end
`else
  assign parity_ok_c = 1'b1;
`endif

  // Lock FSM next-state, slot control and write selection for the accepted word.
  always_comb begin
    state_nxt_c = state;
    miss_nxt_c  = miss_cnt;
    slot_cmd_c  = SLOT_HOLD;
    wr_en_c     = 1'b0;
    wr_idx_c    = '0;
    sync_err_c  = 1'b0;
    if (bus.din_valid) begin
      case (state)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en_c     = 1'b1;
            slot_cmd_c  = SLOT_LOAD1;
            miss_nxt_c  = '0;
            state_nxt_c = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            wr_en_c    = 1'b1;
            sync_err_c = (slot != '0);
            slot_cmd_c = SLOT_LOAD1;
            miss_nxt_c = '0;
          end else if (slot == '0) begin
            wr_en_c = 1'b1;
            if (miss_inc_c == MISS_W'(MISS_LIMIT)) begin
              miss_nxt_c  = '0;
              slot_cmd_c  = SLOT_CLR;
              state_nxt_c = HUNT;
            end else begin
              miss_nxt_c = miss_inc_c;
              slot_cmd_c = SLOT_LOAD1;
            end
          end else begin
            wr_en_c    = 1'b1;
            wr_idx_c   = slot;
            slot_cmd_c = SLOT_INC;
          end
        end
        default: state_nxt_c = HUNT;
      endcase
    end
  end

  assign wr_ok_c = wr_en_c && parity_ok_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      miss_cnt     <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state        <= state_nxt_c;
      miss_cnt     <= miss_nxt_c;
      sync_err_q   <= sync_err_c;
      frame_done_q <= wr_ok_c && (wr_idx_c == SW'(CHANNELS - 1));
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        ch_valid_q[k] <= wr_ok_c && (wr_idx_c == SW'(k));
        if (wr_ok_c && (wr_idx_c == SW'(k))) ch_data_q[k*WIDTH +: WIDTH] <= wr_data_c;
      end
    end
  end

  assign bus.ch_data    = ch_data_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (WIDTH=8, CHANNELS=4, MISS_LIMIT=3).
module tb_tdm_demux;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned DW = 9;
`else
  localparam int unsigned DW = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  tdm_demux_if #(.WIDTH(8), .CHANNELS(4)) bus ();

  tdm_demux #(.WIDTH(8), .CHANNELS(4), .MISS_LIMIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [DW-1:0] w, input logic s);
    @(negedge clk);
    bus.din        = w;
    bus.din_valid  = 1'b1;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
`ifdef TDM_DEMUX_PARITY_EN
    drive({^d, d}, s);
`else
    drive(d, s);
`endif
  endtask

  task automatic idle();
    @(negedge clk);
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic [3:0] v, input logic fd, input logic se);
    chk({tag, ".ch_valid"}, 64'(bus.ch_valid), 64'(v));
    chk({tag, ".frame_done"}, 64'(bus.frame_done), 64'(fd));
    chk({tag, ".sync_err"}, 64'(bus.sync_err), 64'(se));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ch_data", 64'(bus.ch_data), 64'h0);
    chk("rst.locked", 64'(bus.locked), 64'h0);
    chk_pulses("rst", 4'b0000, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    chk("rst.parity_err", 64'(bus.parity_err), 64'h0);
`endif
    rst_n = 1'b1;

    // Words before any sync are dropped
    send(8'hAA, 1'b0);
    chk_pulses("hunt_aa", 4'b0000, 1'b0, 1'b0);
    chk("hunt_aa.locked", 64'(bus.locked), 64'h0);
    send(8'hBB, 1'b0);
    chk("hunt_bb.ch_data", 64'(bus.ch_data), 64'h0);
    chk("hunt_bb.locked", 64'(bus.locked), 64'h0);

    // First aligned frame
    send(8'h11, 1'b1);
    chk_pulses("f0_s0", 4'b0001, 1'b0, 1'b0);
    chk("f0_s0.locked", 64'(bus.locked), 64'h1);
    chk("f0_s0.ch_data", 64'(bus.ch_data), 64'h0000_0011);
    send(8'h22, 1'b0);
    chk_pulses("f0_s1", 4'b0010, 1'b0, 1'b0);
    send(8'h33, 1'b0);
    chk_pulses("f0_s2", 4'b0100, 1'b0, 1'b0);
    send(8'h44, 1'b0);
    chk_pulses("f0_s3", 4'b1000, 1'b1, 1'b0);
    chk("f0_s3.ch_data", 64'(bus.ch_data), 64'h4433_2211);

    // Misplaced sync at expected slot 2 realigns to ch0
    send(8'h55, 1'b1);
    chk_pulses("f1_s0", 4'b0001, 1'b0, 1'b0);
    send(8'h66, 1'b0);
    send(8'h5A, 1'b1);
    chk_pulses("missync", 4'b0001, 1'b0, 1'b1);
    chk("missync.ch_data", 64'(bus.ch_data), 64'h4433_665A);
    chk("missync.locked", 64'(bus.locked), 64'h1);
    send(8'h77, 1'b0);
    chk_pulses("realign_s1", 4'b0010, 1'b0, 1'b0);
    chk("realign_s1.ch_data", 64'(bus.ch_data), 64'h4433_775A);
    send(8'h88, 1'b0);
    send(8'h99, 1'b0);
    chk_pulses("realign_s3", 4'b1000, 1'b1, 1'b0);
    chk("realign_s3.ch_data", 64'(bus.ch_data), 64'h9988_775A);

    // Flywheel: two full frames without sync stay locked
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) send(8'(8'hA0 + 16 * f + s), 1'b0);
      chk($sformatf("fly%0d.locked", f), 64'(bus.locked), 64'h1);
      chk($sformatf("fly%0d.frame_done", f), 64'(bus.frame_done), 64'h1);
    end
    chk("fly.ch_data", 64'(bus.ch_data), 64'hB3B2_B1B0);
    // Third missing sync: still written, then lock drops
    send(8'hC0, 1'b0);
    chk_pulses("fly_c0", 4'b0001, 1'b0, 1'b0);
    chk("fly_c0.locked", 64'(bus.locked), 64'h0);
    chk("fly_c0.ch_data", 64'(bus.ch_data), 64'hB3B2_B1C0);
    send(8'hC1, 1'b0);
    chk_pulses("hunt_c1", 4'b0000, 1'b0, 1'b0);
    chk("hunt_c1.ch_data", 64'(bus.ch_data), 64'hB3B2_B1C0);

    // Valid gaps do not advance the slot
    send(8'h10, 1'b1);
    chk("gap_s0.locked", 64'(bus.locked), 64'h1);
    idle();
    chk_pulses("gap_idle1", 4'b0000, 1'b0, 1'b0);
    idle();
    send(8'h20, 1'b0);
    chk_pulses("gap_s1", 4'b0010, 1'b0, 1'b0);
    chk("gap_s1.ch_data", 64'(bus.ch_data), 64'hB3B2_2010);
    idle();

    // Asynchronous reset mid-frame
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.ch_data", 64'(bus.ch_data), 64'h0);
    chk("midrst.locked", 64'(bus.locked), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h30, 1'b0);
    chk_pulses("postrst_nosync", 4'b0000, 1'b0, 1'b0);
    chk("postrst_nosync.locked", 64'(bus.locked), 64'h0);
    send(8'h40, 1'b1);
    chk_pulses("postrst_sync", 4'b0001, 1'b0, 1'b0);
    chk("postrst_sync.locked", 64'(bus.locked), 64'h1);
    chk("postrst_sync.ch_data", 64'(bus.ch_data), 64'h0000_0040);

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity in slot 1: not stored, slot still advances
    drive(9'h103, 1'b0);
    chk("par_bad.parity_err", 64'(bus.parity_err), 64'h1);
    chk("par_bad.ch_valid", 64'(bus.ch_valid), 64'h0);
    chk("par_bad.ch_data", 64'(bus.ch_data), 64'h0000_0040);
    send(8'h05, 1'b0);
    chk("par_next.parity_err", 64'(bus.parity_err), 64'h0);
    chk("par_next.ch_valid", 64'(bus.ch_valid), 64'b0100);
    chk("par_next.ch_data", 64'(bus.ch_data), 64'h0005_0040);
`endif

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives a word stream carrying CHANNELS interleaved slots per frame, aligns to a frame-sync marker, and distributes each slot to its own per-channel output register. It is the receive end of the team's mux/select datapath: a TDM mux multiplexes channels onto one shared line, and this block recovers them. A lock state machine tracks frame alignment and recovers from missing or misplaced sync markers.

## Interface
Parameters:
- WIDTH, 8: data bits per slot.
- CHANNELS, 4: slots per frame. Legal range is 2..16.
- MISS_LIMIT, 3: consecutive missing syncs that drop lock. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH (WIDTH+1 with TDM_DEMUX_PARITY_EN)  slot word.
- din_valid  in  1  din holds a slot word this cycle.
- frame_sync  in  1  marks the slot-0 word; ignored unless din_valid=1.
- ch_data  out  CHANNELS*WIDTH  per-channel held data; channel k at bits [k*WIDTH +: WIDTH].
- ch_valid  out  CHANNELS  one-cycle pulse per channel when its register is written.
- frame_done  out  1  one-cycle pulse when the last slot (CHANNELS-1) is written.
- locked  out  1  high while in LOCKED state.
- sync_err  out  1  one-cycle pulse on a misplaced sync.
- parity_err  out  1  one-cycle pulse on a parity failure; present only with TDM_DEMUX_PARITY_EN.

## Operation
- Accepted word: a cycle with din_valid=1. Cycles with din_valid=0 change no state; all pulses are 0.
- Slot counter: $clog2(CHANNELS) bits, holds the expected slot. Wraps from CHANNELS-1 to 0.
- State HUNT (reset state):
  - Words without frame_sync are dropped.
  - A word with frame_sync is written to ch0. Slot becomes 1 and the state goes to LOCKED.
- State LOCKED, each accepted word:
  - Expected slot s≠0, no sync: write ch s, slot becomes s+1 (wrapping).
  - Expected slot 0 with sync: write ch0, clear miss_cnt, slot becomes 1.
  - Expected slot 0 without sync (flywheel):
    - Write ch0, increment miss_cnt, slot becomes 1.
    - If miss_cnt reaches MISS_LIMIT, the word is still written, then the state goes to HUNT with miss_cnt=0 and slot=0.
  - Sync at expected slot s≠0 (misplaced): pulse sync_err, realign by writing ch0, slot becomes 1, clear miss_cnt. The state stays LOCKED.
- Writing ch k: ch_data[k] <= data and ch_valid[k] pulses. Other channels hold their values.
- frame_done pulses on the write to ch CHANNELS-1. It does not pulse on a realign write to ch0.
- ch_data holds its last value indefinitely, including across loss of lock.

## Timing
- Reset values of all outputs and state: ch_data=0, ch_valid=0, frame_done=0, locked=0, sync_err=0, parity_err=0; state=HUNT, slot=0, miss_cnt=0.
- Reset is asynchronous and takes effect mid-frame. The first frame after release requires a fresh sync.
- Latency: all outputs are registered and update on the clock edge after the accepted word's edge, i.e. 1 cycle.
- locked rises 1 cycle after the HUNT sync word. It falls 1 cycle after the word that reaches MISS_LIMIT.
- Back-to-back din_valid is sustained at one word per cycle. There is no backpressure.
- Simultaneous frame_sync and misplaced slot: the sync_err pulse and the ch0 write occur in the same cycle.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - din is WIDTH+1 bits, with the MSB an even-parity bit over din[WIDTH-1:0]. The parity bit is not stored.
  - On a parity failure: pulse parity_err; ch_data and ch_valid are not updated for that word.
  - The slot counter, sync handling and miss_cnt still advance as if the word were good.
- Not defined: din is WIDTH bits, the parity_err port is absent, and there is no parity logic.

## Structure
- Package tdm_pkg holds:
  - the state enum (HUNT, LOCKED);
  - the slot-width function (clog2 of CHANNELS);
  - the miss counter width constant, 4 bits.
- Sub-module tdm_slot_counter holds the slot counter with wrap, realign-to-1 load, and clear. The top level holds the FSM, miss_cnt, channel registers and the parity check.

## Test plan
Parameters: WIDTH=8, CHANNELS=4, MISS_LIMIT=3.
- Reset, then words 0x11(sync),0x22,0x33,0x44 -> ch0..ch3 = 11,22,33,44; ch_valid pulses 0001,0010,0100,1000; frame_done pulses on the 0x44 write; locked=1 from the cycle after 0x11.
- Words before any sync in HUNT (0xAA,0xBB), then a sync frame -> AA/BB dropped, ch_data unchanged from 0, locked=0 until the sync word.
- Locked; sync arrives on expected slot 2 with 0x5A -> sync_err pulse, ch0=5A, the next word lands in ch1, locked stays 1.
- Locked; 3 frames with no sync at slot 0 -> all words written; locked falls 1 cycle after the third slot-0 word; subsequent non-sync words are dropped.
- Word stream with din_valid gaps (1,0,0,1,…) plus rst_n pulsed low mid-frame -> no advance on gaps; reset clears all outputs immediately; the frame restarts only at the next sync.
- With TDM_DEMUX_PARITY_EN: word 0x1_03 (bad parity) in slot 1 -> parity_err pulse, ch1 unchanged, no ch_valid[1]; the next word lands in ch2.
